// File: rtl/seq_mult_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// One multiplier bit is consumed per CALC cycle. The 17-bit {C,ACC,Q} chain
// shifts right each step, so after eight steps the product sits in {ACC,Q}.
module seq_mult_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic [16:0] step;

  // One add-and-shift step. The result is the new {C,ACC,Q}.
  // C is always 0 when a step begins, because the previous shift moved a 0
  // into it. Including C in the addend therefore leaves the sum unchanged.
  function automatic logic [16:0] add_shift(input logic [7:0] a,
                                            input logic       c,
                                            input logic [7:0] acc,
                                            input logic [7:0] q);
    logic [7:0] partial;
    logic [8:0] sum;
    partial = a & {8{q[0]}};
    sum     = {c, acc} + {1'b0, partial};
    return {1'b0, sum, q[7:1]};
  endfunction

  assign step = add_shift(a_q, c_q, acc_q, q_q);

  // State register: reset forces IDLE ahead of any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: reset clears the operands, the partial result and the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic. start is ignored outside IDLE, so requests do not queue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on accept, one shift-add per CALC cycle.
  // The product loads from the final step as the FSM enters DONE.
  always_comb begin
    a_d       = a_q;
    acc_d     = acc_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = multiplicand;
          q_d   = multiplier;
          acc_d = '0;
          c_d   = 1'b0;
          cnt_d = '0;
        end
      end
      CALC: begin
        {c_d, acc_d, q_d} = step;
        cnt_d             = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = step[15:0];
        end
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from the state register, product taken straight from its flop.
  always_comb begin
    busy    = (state_q == CALC);
    done    = (state_q == DONE);
    product = product_q;
  end

endmodule
